// File: rtl/serial_rx.sv
// serial_rx: strobe-driven serial receiver with an optional parity bit and a
// one-entry holding register.
//   clk_i, rst_i   clock; synchronous active-high reset
//   bit_en_i       bit strobe; rx_i is only looked at when it is high
//   rx_i           serial line, idles high
//   ready_i        consumer accepts data_o when valid_o is also high
//   data_o         received word
//   valid_o        data_o holds a word that has not been consumed yet
//   frame_err_o    one-cycle pulse: stop bit sampled low
//   parity_err_o   one-cycle pulse: parity mismatch
//   overflow_o     sticky: a good word was dropped because data_o was full
//   busy_o         a frame is in progress
//
// Frame: start(0), WIDTH data bits LSB first, [parity], stop(1).
// state  | meaning
// IDLE   | waiting for a start strobe with rx_i = 0
// DATA   | capturing data bits into shift_q[cnt_q]
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then deliver or discard the word
module serial_rx #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 0,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_en_i,
  input  logic             rx_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             frame_err_o,
  output logic             parity_err_o,
  output logic             overflow_o,
  output logic             busy_o
);

  if (WIDTH == 0) begin : g_bad_width
    $error("serial_rx: WIDTH must be at least 1");
  end

  localparam int   CNT_W  = $clog2(WIDTH + 1);
  localparam logic PAR_EN = (PARITY_EN != 0);
  localparam logic ODD    = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]   shift_q,     shift_d;
  logic               par_mis_q,   par_mis_d;
  logic [WIDTH-1:0]   data_q,      data_d;
  logic               valid_q,     valid_d;
  logic               frame_err_q, frame_err_d;
  logic               par_err_q,   par_err_d;
  logic               overflow_q,  overflow_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_mis_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_mis_q   <= par_mis_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_mis_d   = par_mis_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    overflow_d  = overflow_q;

    // A handshake empties the holding register; a load below may refill it.
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if (bit_en_i) begin
      case (state_q)
        IDLE: begin
          if (!rx_i) begin
            state_d   = DATA;
            cnt_d     = '0;
            par_mis_d = 1'b0;
          end
        end
        DATA: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              shift_d[i] = rx_i;
            end
          end
          // Counter is sized to hold WIDTH, so the final increment never wraps.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = PAR_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_mis_d = ((^shift_q) ^ rx_i) != ODD;
          state_d   = STOP;
        end
        STOP: begin
          // Always back to IDLE: a low stop bit is an error, never a start.
          state_d = IDLE;
          if (!rx_i) begin
            frame_err_d = 1'b1;
          end else if (PAR_EN && par_mis_q) begin
            par_err_d = 1'b1;
          end else if (!valid_q || ready_i) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = par_err_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != IDLE);

endmodule
